// File: rtl/instr_fetch_q.sv
// Instruction fetch unit: one outstanding memory request, predecode of the returned word, and a small fetch queue.
// Optional build macro FETCH_BTFN_EN: predict backward conditional branches as taken (forward ones not taken).
module instr_fetch_q #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pred_pc,
  input  logic              inst_ready
);

  localparam int unsigned PW = $clog2(QDEPTH);

`ifdef FETCH_BTFN_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH, WAIT, BLOCK, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fpc;
  logic [31:0]       q_inst [QDEPTH];
  logic [ADDR_W-1:0] q_pc   [QDEPTH];
  logic [ADDR_W-1:0] q_pred [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;

  logic              clear;
  logic [ADDR_W-1:0] clear_pc;
  logic              req;
  logic              enq;
  logic              pop;

  // Reset is folded into the redirect path with RESET_PC as the target
  assign clear    = rst | redirect;
  assign clear_pc = rst ? RESET_PC : redirect_pc;
  assign req      = !clear && (state == FETCH) && !stall && (count < (PW+1)'(QDEPTH));
  assign enq      = !clear && (state == WAIT) && mem_valid;
  assign pop      = !clear && inst_ready && (count != '0);

  logic signed [20:0] j_imm;
  logic signed [12:0] b_imm;
  logic signed [11:0] cj_imm;
  logic signed [8:0]  cb_imm;

  assign j_imm  = {mem_data[31], mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0};
  assign b_imm  = {mem_data[31], mem_data[7], mem_data[30:25], mem_data[11:8], 1'b0};
  assign cj_imm = {mem_data[12], mem_data[8], mem_data[10:9], mem_data[6], mem_data[7],
                   mem_data[2], mem_data[11], mem_data[5:3], 1'b0};
  assign cb_imm = {mem_data[12], mem_data[6:5], mem_data[2], mem_data[11:10], mem_data[4:3], 1'b0};

  logic              is_c;
  logic [31:0]       enq_inst;
  logic [ADDR_W-1:0] pred_pc;
  logic              indirect;

  always_comb begin
    is_c     = (mem_data[1:0] != 2'b11);
    enq_inst = is_c ? {16'h0000, mem_data[15:0]} : mem_data;
    pred_pc  = fpc + (is_c ? ADDR_W'(2) : ADDR_W'(4));
    indirect = 1'b0;
    if (!is_c) begin
      case (mem_data[6:0])
        7'b1101111: pred_pc = fpc + ADDR_W'(j_imm);
        7'b1100111: indirect = 1'b1;
        7'b1100011: if (BTFN && b_imm[12]) pred_pc = fpc + ADDR_W'(b_imm);
        default: ;
      endcase
    end else if (mem_data[1:0] == 2'b01) begin
      if (mem_data[15:13] == 3'b101)
        pred_pc = fpc + ADDR_W'(cj_imm);
      else if (mem_data[15:14] == 2'b11 && BTFN && cb_imm[8])
        pred_pc = fpc + ADDR_W'(cb_imm);
    end else if (mem_data[1:0] == 2'b10) begin
      indirect = (mem_data[15:13] == 3'b100) && (mem_data[11:7] != '0) && (mem_data[6:2] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      fpc    <= clear_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // A redirect with a response still in flight must swallow that response first
      state  <= (!rst && (state == WAIT || state == DRAIN) && !mem_valid) ? DRAIN : FETCH;
    end else begin
      if (enq) begin
        q_inst[wr_ptr] <= enq_inst;
        q_pc[wr_ptr]   <= fpc;
        q_pred[wr_ptr] <= pred_pc;
        wr_ptr         <= wr_ptr + 1'b1;
        fpc            <= pred_pc;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (enq && !pop)
        count <= count + 1'b1;
      else if (pop && !enq)
        count <= count - 1'b1;
      case (state)
        FETCH:   if (req) state <= WAIT;
        WAIT:    if (mem_valid) state <= indirect ? BLOCK : FETCH;
        BLOCK:   state <= BLOCK;
        DRAIN:   if (mem_valid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign mem_req      = req;
  assign mem_addr     = rst ? '0 : fpc;
  assign inst_valid   = !rst && (count != '0);
  assign inst         = q_inst[rd_ptr];
  assign inst_pc      = q_pc[rd_ptr];
  assign inst_pred_pc = q_pred[rd_ptr];

endmodule

// File: tb/tb_instr_fetch_q.sv
// Self-checking bench for instr_fetch_q: queue-based reference model plus directed vectors with literal expectations.
module tb_instr_fetch_q;

  localparam int unsigned AW  = 32;
  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0;

`ifdef FETCH_BTFN_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall, mem_req, mem_valid, redirect, inst_valid, inst_ready;
  logic [AW-1:0] mem_addr, redirect_pc, inst_pc, inst_pred_pc;
  logic [31:0]   mem_data, inst;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  instr_fetch_q #(.ADDR_W(AW), .QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pred_pc(inst_pred_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endfunction

  // Reference model: queue of {inst, pc, pred} plus a few flags
  typedef struct { logic [31:0] inst; logic [AW-1:0] pc; logic [AW-1:0] pred; } ent_t;
  ent_t          mq[$];
  logic [AW-1:0] m_fpc;
  bit            m_out, m_drain, m_block;

  function automatic longint sext(input logic [31:0] v, input int n);
    longint x = longint'(v);
    if (v[n-1]) x = x - (longint'(1) << n);
    return x;
  endfunction

  function automatic void predict(input logic [AW-1:0] pc, input logic [31:0] d,
                                  output ent_t e, output bit ind);
    longint off;
    ind = 1'b0;
    if (d[1:0] == 2'b11) begin
      e.inst = d;
      off = 4;
      if (d[6:0] == 7'h6F) off = sext({d[31], d[19:12], d[20], d[30:21], 1'b0}, 21);
      if (d[6:0] == 7'h67) ind = 1'b1;
      if (d[6:0] == 7'h63 && BTFN && d[31]) off = sext({d[31], d[7], d[30:25], d[11:8], 1'b0}, 13);
    end else begin
      e.inst = {16'h0, d[15:0]};
      off = 2;
      if (d[1:0] == 2'b01 && d[15:13] == 3'b101)
        off = sext({d[12], d[8], d[10:9], d[6], d[7], d[2], d[11], d[5:3], 1'b0}, 12);
      if (d[1:0] == 2'b01 && d[15:14] == 2'b11 && BTFN && d[12])
        off = sext({d[12], d[6:5], d[2], d[11:10], d[4:3], 1'b0}, 9);
      if (d[1:0] == 2'b10 && d[15:13] == 3'b100 && d[11:7] != 0 && d[6:2] == 0) ind = 1'b1;
    end
    e.pc   = pc;
    e.pred = pc + AW'(off);
  endfunction

  function automatic bit exp_req();
    return !rst && !redirect && !stall && !m_out && !m_block && (mq.size() < QD);
  endfunction

  always @(posedge clk) begin : model_step
    bit   rq, pop_ok, ind;
    ent_t e;
    rq     = exp_req();
    pop_ok = inst_ready && (mq.size() > 0);
    if (rst) begin
      mq.delete(); m_fpc = RPC; m_out = 0; m_drain = 0; m_block = 0;
    end else if (redirect) begin
      mq.delete(); m_fpc = redirect_pc; m_block = 0;
      if (m_out && mem_valid) begin m_out = 0; m_drain = 0; end
      else if (m_out) m_drain = 1;
    end else begin
      if (pop_ok) void'(mq.pop_front());
      if (m_out && mem_valid) begin
        m_out = 0;
        if (m_drain) m_drain = 0;
        else begin
          predict(m_fpc, mem_data, e, ind);
          mq.push_back(e);
          m_fpc   = e.pred;
          m_block = ind;
        end
      end
      if (rq) m_out = 1;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      if (rst) begin
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
      end else begin
        chk("mem_req", mem_req, exp_req());
        if (mem_req) chk("mem_addr", mem_addr, m_fpc);
        chk("inst_valid", inst_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("inst", inst, mq[0].inst);
          chk("inst_pc", inst_pc, mq[0].pc);
          chk("inst_pred_pc", inst_pred_pc, mq[0].pred);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string nm, input logic [AW-1:0] addr, output int waited);
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_req === 1'b1) begin waited = i; break; end
      tick();
    end
    if (waited < 0) begin
      checks++; failures++;
      $display("FAIL %s: no mem_req within 20 cycles, expected addr %h", nm, addr);
    end else chk(nm, mem_addr, addr);
  endtask

  task automatic respond(input string nm, input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic stall_after, output int waited);
    wait_req(nm, addr, waited);
    tick();
    mem_valid = 1'b1; mem_data = data; stall = stall_after;
    tick();
    mem_valid = 1'b0; mem_data = '0;
  endtask

  task automatic serve(input int cycles, inout int n);
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (mem_req === 1'b1) begin
        n++;
        tick();
        mem_valid = 1'b1; mem_data = 32'h13;
        tick();
        mem_valid = 1'b0;
      end else tick();
    end
  endtask

  typedef struct { logic [31:0] pc, data, inst, pred; bit blk; } vec_t;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, nreq;
    vec_t tv[$];
    tv.push_back('{32'h10,       32'hFE000EE3, 32'hFE000EE3, BTFN ? 32'hC : 32'h14, 1'b0});
    tv.push_back('{32'h40,       32'h0080006F, 32'h0080006F, 32'h48,       1'b0});
    tv.push_back('{32'h4,        32'hFF9FF06F, 32'hFF9FF06F, 32'hFFFFFFFC, 1'b0});
    tv.push_back('{32'h60,       32'h5555A801, 32'h0000A801, 32'h70,       1'b0});
    tv.push_back('{32'h70,       32'h0000BFFD, 32'h0000BFFD, 32'h6E,       1'b0});
    tv.push_back('{32'h90,       32'h0000DC7D, 32'h0000DC7D, BTFN ? 32'h8E : 32'h92, 1'b0});
    tv.push_back('{32'hA0,       32'h00000463, 32'h00000463, 32'hA4,       1'b0});
    tv.push_back('{32'h80,       32'h00008082, 32'h00008082, 32'h82,       1'b1});
    tv.push_back('{32'h20,       32'h00008067, 32'h00008067, 32'h24,       1'b1});
    tv.push_back('{32'h100,      32'h00000013, 32'h00000013, 32'h104,      1'b0});
    tv.push_back('{32'hFFFFFFFC, 32'h00000013, 32'h00000013, 32'h0,        1'b0});
    tv.push_back('{32'hFFFFFFFE, 32'hFFFF0001, 32'h00000001, 32'h0,        1'b0});

    rst = 1; stall = 0; mem_valid = 0; mem_data = '0; redirect = 0; redirect_pc = '0; inst_ready = 0;
    tick(); run_cmp = 1'b1;
    tick(); tick();
    #1;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_inst_valid", inst_valid, 1'b0);
    chk("reset_mem_addr", mem_addr, '0);
    rst = 0;

    // First fetch right after reset, then stall so the queue holds just this entry
    respond("first_req_addr", 32'h0, 32'h00000013, 1'b1, w);
    chk("first_req_latency", w, 0);
    #1;
    chk("first_valid", inst_valid, 1'b1);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_pred", inst_pred_pc, 32'h4);
    chk("first_inst", inst, 32'h13);
    inst_ready = 1; tick(); inst_ready = 0; stall = 0;
    #1 chk("popped_empty", inst_valid, 1'b0);

    respond("c_req_addr", 32'h4, 32'hDEAD0001, 1'b1, w);
    #1;
    chk("c_inst", inst, 32'h00000001);
    chk("c_pred", inst_pred_pc, 32'h6);
    stall = 0;
    wait_req("c_next_addr", 32'h6, w);

    // Redirect while waiting; the late response must be swallowed
    tick();
    redirect = 1; redirect_pc = 32'h200; tick(); redirect = 0;
    mem_valid = 1; mem_data = 32'h13; tick(); mem_valid = 0;
    #1 chk("drop_valid", inst_valid, 1'b0);
    respond("post_drain_addr", 32'h200, 32'h13, 1'b1, w);
    #1 chk("post_drain_pc", inst_pc, 32'h200);

    for (int i = 0; i < tv.size(); i++) begin
      stall = 1; redirect = 1; redirect_pc = tv[i].pc; tick(); redirect = 0; stall = 0;
      #1 chk($sformatf("v%0d_cleared", i), inst_valid, 1'b0);
      respond($sformatf("v%0d_addr", i), tv[i].pc, tv[i].data, 1'b1, w);
      #1;
      chk($sformatf("v%0d_inst", i), inst, tv[i].inst);
      chk($sformatf("v%0d_pc", i), inst_pc, tv[i].pc);
      chk($sformatf("v%0d_pred", i), inst_pred_pc, tv[i].pred);
      if (tv[i].blk) begin
        stall = 0;
        repeat (4) tick();
        #1 chk($sformatf("v%0d_blocked", i), mem_req, 1'b0);
      end
    end

    // Capacity: with no pops only QD requests go out; one pop frees one slot
    stall = 1; redirect = 1; redirect_pc = 32'h300; tick(); redirect = 0; stall = 0;
    nreq = 0;
    serve(30, nreq);
    chk("cap_nreq", nreq, 4);
    chk("cap_valid", inst_valid, 1'b1);
    chk("cap_head", inst_pc, 32'h300);
    inst_ready = 1; tick(); inst_ready = 0;
    serve(15, nreq);
    chk("cap_after_pop", nreq, 5);
    chk("cap_head2", inst_pc, 32'h304);

    // Continuous consumption: simultaneous enqueue/pop and pointer wrap
    inst_ready = 1;
    serve(40, nreq);
    inst_ready = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
